// File: rtl/target_checker.sv
// Consumer of the LFSR word: latches a nonzero hex target, collects a
// two-nibble guess, and scores rounds against a per-round timeout.
module target_checker #(
  parameter int TIMEOUT = 1000000,
  parameter int LIVES   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rand_val,
  input  logic        start,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  output logic [7:0]  target,
  output logic        target_valid,
  output logic        hit,
  output logic        miss,
  output logic        timeout,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        game_over
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WHI,
    S_WLO,
    S_CHECK,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_timer;
  logic [3:0]     r_guess_hi;
  logic [7:0]     w_cand;
  logic           w_cand_ok;
  logic           w_expired;
  logic           w_match;
  logic           w_unused;

  assign w_cand    = rand_val[7:0];
  assign w_unused  = ^rand_val[15:8];
  assign w_cand_ok = (w_cand != 8'h00) && (w_cand != target);
  // >= covers a high digit taken on the last cycle, which pushes the
  // timer one past the limit before the low nibble arrives
  assign w_expired = r_timer >= TW'(TIMEOUT - 1);
  assign w_match   = {r_guess_hi, digit_in} == target;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_cand_ok) w_next = S_WHI;
      S_WHI: begin
        if (digit_valid)    w_next = S_WLO;
        else if (w_expired) w_next = S_CHECK;
      end
      S_WLO: begin
        if (digit_valid || w_expired) w_next = S_CHECK;
      end
      S_CHECK: w_next = (lives == 3'd0) ? S_DONE : S_LOAD;
      S_DONE:  if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      target       <= 8'h00;
      target_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      timeout      <= 1'b0;
      score        <= 16'h0000;
      lives        <= 3'(LIVES);
      game_over    <= 1'b0;
      r_timer      <= '0;
      r_guess_hi   <= 4'h0;
    end else begin
      hit          <= 1'b0;
      miss         <= 1'b0;
      timeout      <= 1'b0;
      target_valid <= (w_next == S_WHI) || (w_next == S_WLO);
      game_over    <= (w_next == S_DONE);
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score <= 16'h0000;
            lives <= 3'(LIVES);
          end
        end
        S_LOAD: begin
          if (w_cand_ok) begin
            target  <= w_cand;
            r_timer <= '0;
          end
        end
        S_WHI: begin
          if (digit_valid) begin
            r_guess_hi <= digit_in;
            r_timer    <= r_timer + 1'b1;
          end else if (w_expired) begin
            timeout <= 1'b1;
            miss    <= 1'b1;
            lives   <= lives - 3'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WLO: begin
          if (digit_valid) begin
            if (w_match) begin
              hit <= 1'b1;
              if (score != 16'hFFFF) score <= score + 16'd1;
            end else begin
              miss  <= 1'b1;
              lives <= lives - 3'd1;
            end
          end else if (w_expired) begin
            timeout <= 1'b1;
            miss    <= 1'b1;
            lives   <= lives - 3'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_target_checker.sv
// Randomized scoreboard bench for target_checker: rounds are driven as
// transactions, a game-level model predicts each scored pulse.
module tb_target_checker;

  localparam int TO = 16;
  localparam int LV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rand_val = 16'h0000;
  logic        start = 1'b0;
  logic [3:0]  digit_in = 4'h0;
  logic        digit_valid = 1'b0;
  logic [7:0]  target;
  logic        target_valid;
  logic        hit;
  logic        miss;
  logic        timeout;
  logic [15:0] score;
  logic [2:0]  lives;
  logic        game_over;

  target_checker #(.TIMEOUT(TO), .LIVES(LV)) dut (
    .clk(clk),
    .rst(rst),
    .rand_val(rand_val),
    .start(start),
    .digit_in(digit_in),
    .digit_valid(digit_valid),
    .target(target),
    .target_valid(target_valid),
    .hit(hit),
    .miss(miss),
    .timeout(timeout),
    .score(score),
    .lives(lives),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  tgt;
    bit          h;
    bit          to;
    logic [15:0] sc;
    logic [2:0]  lv;
    int          at;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [15:0] vq[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  m_target = 8'h00;
  logic [15:0] m_score = 16'h0000;
  logic [2:0]  m_lives = 3'(LV);

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_exp(bit h, bit to, int at);
    exp_t e;
    if (h) begin
      if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
    end else begin
      m_lives = m_lives - 3'd1;
    end
    e.tgt = m_target;
    e.h = h;
    e.to = to;
    e.sc = m_score;
    e.lv = m_lives;
    e.at = at;
    q.push_back(e);
  endfunction

  // Monitor: every scored pulse must match the oldest predicted outcome
  always @(negedge clk) begin
    if (rst && (hit || miss || timeout)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, hit, miss, timeout}, 32'd0);
      end else begin
        me = q.pop_front();
        chk("hit", hit, me.h);
        chk("miss", miss, !me.h);
        chk("timeout", timeout, me.to);
        chk("pulse_target", target, me.tgt);
        chk("score", score, me.sc);
        chk("lives", lives, me.lv);
        chk("pulse_cycle", cyc, me.at);
        chk("tv_in_check", target_valid, 1'b0);
      end
    end
  end

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_score = 16'h0000;
    m_lives = 3'(LV);
    chk("start_score", score, 0);
    chk("start_lives", lives, LV);
    chk("start_over", game_over, 0);
  endtask

  // Target is the first offered byte that is nonzero and differs from
  // the previous target; one candidate is offered per cycle.
  task automatic do_load(output int e);
    int idx;
    int n;
    bit ok;
    logic [15:0] v;
    idx = vq.size() - 1;
    for (int i = vq.size() - 1; i >= 0; i--) begin
      v = vq[i];
      if (v[7:0] != 8'h00 && v[7:0] != m_target) idx = i;
    end
    ok = 0;
    n = -1;
    for (int i = 0; i < vq.size() + 2 && !ok; i++) begin
      v = (i < vq.size()) ? vq[i] : vq[vq.size() - 1];
      rand_val = v;
      @(negedge clk);
      if (target_valid) begin
        ok = 1;
        n = i;
      end
    end
    chk("load_cycles", n, idx);
    v = vq[idx];
    chk("target_load", target, v[7:0]);
    m_target = v[7:0];
    e = cyc;
  endtask

  // mode 0: both digits, mode 1: no digits, mode 2: high digit only
  task automatic round(input int mode, input int dh, input int dl,
                       input bit aim, input logic [3:0] hi_in,
                       input logic [3:0] lo_in);
    int e;
    int w;
    logic [3:0] hi;
    logic [3:0] lo;
    do_load(e);
    hi = aim ? m_target[7:4] : hi_in;
    lo = aim ? m_target[3:0] : lo_in;
    if (mode == 1) begin
      push_exp(0, 1, e + TO);
    end else begin
      repeat (dh) @(negedge clk);
      digit_in = hi;
      digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
      if (mode == 2) begin
        push_exp(0, 1, e + TO);
      end else begin
        repeat (dl) @(negedge clk);
        digit_in = lo;
        digit_valid = 1'b1;
        push_exp({hi, lo} == m_target, 0, cyc + 1);
        @(negedge clk);
        digit_valid = 1'b0;
      end
    end
    w = 0;
    while (!(hit || miss) && w < 3 * TO) begin
      @(negedge clk);
      w++;
    end
    chk("pulse_seen", hit || miss, 1);
    @(negedge clk);
    if (m_lives == 3'd0) begin
      chk("game_over", game_over, 1);
      chk("tv_done", target_valid, 0);
      chk("target_hold", target, m_target);
      repeat (3) begin
        digit_in = 4'($urandom);
        digit_valid = 1'b1;
        @(negedge clk);
      end
      digit_valid = 1'b0;
      @(negedge clk);
      chk("still_over", game_over, 1);
      chk("lives_zero", lives, 0);
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_target"}, target, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, LV);
    chk({tag, "_tv"}, target_valid, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_pulses"}, {hit, miss, timeout}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int mode;
    int dh;
    int dl;
    int e;
    bit aim;
    logic [7:0] lb;
    logic [15:0] v;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    start_game();

    vq.delete();
    vq.push_back(16'h6A47);
    round(0, 1, 0, 0, 4'h4, 4'h7);

    vq.delete();
    repeat (3) vq.push_back(16'h0000);
    vq.push_back(16'h00C3);
    round(0, 0, 0, 0, 4'h4, 4'h8);

    vq.delete();
    vq.push_back(16'h12C3);
    vq.push_back(16'h0015);
    round(0, 3, 11, 0, 4'h1, 4'h5);

    vq.delete();
    vq.push_back(16'hBEEF);
    round(1, 0, 0, 0, 4'h0, 4'h0);

    vq.delete();
    vq.push_back(16'h0042);
    round(2, 5, 0, 0, 4'h0, 4'h0);
    start_game();

    for (int r = 0; r < 40; r++) begin
      vq.delete();
      n = $urandom_range(0, 2);
      repeat (n) begin
        v = 16'($urandom);
        if ($urandom % 2 == 0) v[7:0] = 8'h00;
        else v[7:0] = m_target;
        vq.push_back(v);
      end
      do lb = 8'($urandom_range(1, 255)); while (lb == m_target);
      v = 16'($urandom);
      v[7:0] = lb;
      vq.push_back(v);
      mode = $urandom_range(0, 5);
      mode = (mode < 4) ? 0 : mode - 3;
      dh = $urandom_range(0, 14);
      dl = $urandom_range(0, 14 - dh);
      aim = ($urandom % 2) == 0;
      round(mode, dh, dl, aim, 4'($urandom), 4'($urandom));
      if (m_lives == 3'd0) start_game();
    end

    vq.delete();
    do lb = 8'($urandom_range(1, 255)); while (lb == m_target);
    vq.push_back({8'h00, lb});
    do_load(e);
    digit_in = 4'h4;
    digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    rst = 1'b1;
    m_target = 8'h00;
    m_score = 16'h0000;
    m_lives = 3'(LV);
    repeat (2) @(negedge clk);
    chk("idle_after_reset_tv", target_valid, 0);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/target_checker.md
Name: target_checker

Overview:
- Consumer end of the random-target path: takes the 16-bit pseudo-random word from the LFSR and latches its low byte as the current hex target.
- Collects a two-nibble player guess (high nibble first), compares it to the target, and scores the round.
- Tracks score and remaining lives, and enforces a per-round timeout.
- Sits between the LFSR/keypad inputs and the display/game-control logic.

Parameters:
- TIMEOUT, 1000000, clock cycles allowed per round (tests use 16).
- LIVES, 3, misses/timeouts tolerated before game over (1..7).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- rand_val  input  16  LFSR output; only bits [7:0] are used
- start  input  1  starts a game; sampled only in IDLE and DONE
- digit_in  input  4  player hex digit
- digit_valid  input  1  digit_in is valid this cycle (one-cycle strobe per digit)
- target  output  8  current target byte
- target_valid  output  1  high while WAIT_HI or WAIT_LO
- hit  output  1  one-cycle pulse, correct guess
- miss  output  1  one-cycle pulse, wrong guess or timeout
- timeout  output  1  one-cycle pulse, round expired (miss also high)
- score  output  16  correct-guess count, saturates at 16'hFFFF
- lives  output  3  remaining lives
- game_over  output  1  level, high in DONE

Behaviour:
- Reset (rst=0 at posedge, any state):
  - state=IDLE; target=0, score=0, lives=LIVES, timer=0, guess_hi=0.
  - hit=0, miss=0, timeout=0, target_valid=0, game_over=0.
  - A reset mid-round discards the round with no pulse.
- All outputs are registered. States: IDLE, LOAD, WAIT_HI, WAIT_LO, CHECK, DONE.
- IDLE:
  - start=1 -> LOAD; score=0, lives=LIVES on that edge.
  - Otherwise stay in IDLE.
- LOAD:
  - Sample rand_val[7:0].
  - If it is 8'h00 or equals the current target, stay in LOAD and resample next cycle.
  - Else target<=rand_val[7:0], timer<=0, go to WAIT_HI.
- WAIT_HI:
  - digit_valid=1 -> guess_hi<=digit_in, timer+1, go to WAIT_LO.
  - Else if timer==TIMEOUT-1 -> timeout path.
  - Else timer+1.
- WAIT_LO:
  - Timer keeps counting from WAIT_HI; it is not cleared between nibbles.
  - digit_valid=1 -> compare {guess_hi,digit_in} with target and go to CHECK:
    - match: hit<=1, score<=score+1 (saturating).
    - mismatch: miss<=1, lives<=lives-1.
  - Else if timer==TIMEOUT-1 -> timeout path.
- Timeout path: timeout<=1, miss<=1, lives<=lives-1, go to CHECK.
- Simultaneous digit_valid and timer==TIMEOUT-1: the digit wins and no timeout is raised.
- CHECK (exactly 1 cycle):
  - The pulses are high during this cycle; score and lives already show their updated values.
  - Next edge clears the pulses and goes to DONE if lives==0, else to LOAD.
  - digit_valid in CHECK and LOAD is ignored.
- DONE:
  - game_over=1; target holds its last value.
  - start=1 -> LOAD, with score=0, lives=LIVES and game_over cleared on that edge.
- start outside IDLE/DONE is ignored. lives never underflows: DONE is entered at 0.
- Latency:
  - Last digit to hit/miss: 1 cycle.
  - Hit/miss to target_valid on the next round: minimum 2 cycles (CHECK -> LOAD -> WAIT_HI).

Test Plan:
- Reset, then start with rand_val=16'h6A47: target=8'h47, target_valid high 2 cycles after start; digits 4,7 -> hit pulse 1 cycle, score=1, lives=3.
- target=8'h47, digits 4,8 -> miss pulse, hit=0, score unchanged, lives=2.
- rand_val held at 16'h0000 for 3 cycles, then 16'h00C3 -> LOAD persists 3 cycles, then target=8'hC3; then rand_val=16'h12C3 in the next LOAD -> resampled, target stays C3 until a different value such as 16'h0015 gives target=8'h15.
- TIMEOUT=16, no digits -> timeout and miss pulse together 16 cycles after entering WAIT_HI; lives decremented.
- TIMEOUT=16, digit_valid coincident with timer==15 -> digit accepted, no timeout.
- Three misses -> game_over=1, lives=0, state DONE; digits ignored; start -> lives=3, score=0, LOAD. Separately: rst=0 while in WAIT_LO -> all outputs at reset values next cycle, no pulse.
